// File: rtl/gpr_wb_arbiter_pkg.sv
// Shared types for the GPR write-port arbiter: register geometry, the
// buffered writeback entry, and the port-select encoding.
package gpr_wb_arbiter_pkg;

  localparam int GPR_NUM     = 32;
  localparam int GPR_ID_BITS = $clog2(GPR_NUM);
  localparam int GPR_BITS    = 32;

  typedef logic [GPR_ID_BITS-1:0] gpr_id_t;
  typedef logic [GPR_BITS-1:0]    gpr_val_t;

  typedef struct packed {
    gpr_id_t  id;
    gpr_val_t val;
  } wb_entry;

  typedef enum logic {
    WB_PORT_A = 1'b0,
    WB_PORT_B = 1'b1
  } wb_port_e;

endpackage

// File: rtl/wb_fifo.sv
// Small circular FIFO of writeback entries; also exposes every slot's
// valid bit and destination id so the owner can do a pending-write lookup.
module wb_fifo
  import gpr_wb_arbiter_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push,
  input  wb_entry               push_data,
  input  logic                  pop,
  output wb_entry               head,
  output logic                  full,
  output logic                  empty,
  output logic [DEPTH-1:0]      ent_valid,
  output gpr_id_t [DEPTH-1:0]   ent_id
);

  localparam int PW = $clog2(DEPTH);

  wb_entry         mem_q [DEPTH];
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PW:0]     count_q, count_d;
  logic            do_push, do_pop;

  assign full    = (count_q == (PW+1)'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem_q[rd_ptr_q];

  // NOTE: every signal written in always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    unique case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // A slot is live when its distance from the read pointer is below the count.
  always_comb begin
    ent_valid = '0;
    ent_id    = '0;
    for (int i = 0; i < DEPTH; i++) begin
      logic [PW-1:0] offset;
      offset       = PW'(i) - rd_ptr_q;
      ent_valid[i] = ({1'b0, offset} < count_q);
      ent_id[i]    = mem_q[i].id;
    end
  end

  // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: storage is deliberately not reset; slot contents are meaningless until count_q covers them.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/gpr_wb_arbiter.sv
// Two-producer writeback arbiter for the single GPR write port, with
// per-register pending-write lookup for the issue stage and a sticky conflict flag.
module gpr_wb_arbiter
  import gpr_wb_arbiter_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic     clk,
  input  logic     rst_n,
  input  logic     a_valid,
  output logic     a_ready,
  input  gpr_id_t  a_id,
  input  gpr_val_t a_val,
  input  logic     b_valid,
  output logic     b_ready,
  input  gpr_id_t  b_id,
  input  gpr_val_t b_val,
  output logic     we,
  output gpr_id_t  write_id,
  output gpr_val_t write_val,
  input  gpr_id_t  rs1_id,
  input  gpr_id_t  rs2_id,
  output logic     rs1_busy,
  output logic     rs2_busy,
  output logic     conflict
);

  wb_entry              a_head, b_head, a_in, b_in;
  logic                 a_full, a_empty, b_full, b_empty;
  logic [DEPTH-1:0]     a_ent_valid, b_ent_valid;
  gpr_id_t [DEPTH-1:0]  a_ent_id, b_ent_id;
  logic                 a_push, b_push, grant_a, grant_b;

  logic     we_q, we_d;
  gpr_id_t  write_id_q, write_id_d;
  gpr_val_t write_val_q, write_val_d;
  wb_port_e last_grant_q, last_grant_d;
  logic     conflict_q, conflict_d;

  assign a_ready = !a_full;
  assign b_ready = !b_full;
  // x0 writes complete the handshake but are dropped here.
  assign a_push  = a_valid && a_ready && (a_id != '0);
  assign b_push  = b_valid && b_ready && (b_id != '0);
  assign a_in    = '{id: a_id, val: a_val};
  assign b_in    = '{id: b_id, val: b_val};

  wb_fifo #(.DEPTH(DEPTH)) u_fifo_a (
    .clk, .rst_n, .push(a_push), .push_data(a_in), .pop(grant_a), .head(a_head),
    .full(a_full), .empty(a_empty), .ent_valid(a_ent_valid), .ent_id(a_ent_id)
  );

  wb_fifo #(.DEPTH(DEPTH)) u_fifo_b (
    .clk, .rst_n, .push(b_push), .push_data(b_in), .pop(grant_b), .head(b_head),
    .full(b_full), .empty(b_empty), .ent_valid(b_ent_valid), .ent_id(b_ent_id)
  );

  function automatic logic pending(input gpr_id_t id);
    logic hit;
    hit = we_q && (write_id_q == id);
    for (int i = 0; i < DEPTH; i++) begin
      hit |= a_ent_valid[i] && (a_ent_id[i] == id);
      hit |= b_ent_valid[i] && (b_ent_id[i] == id);
    end
    return (id != '0) && hit;
  endfunction

  always_comb begin
    grant_a      = !a_empty && (b_empty || last_grant_q == WB_PORT_B);
    grant_b      = !b_empty && !grant_a;
    we_d         = grant_a || grant_b;
    write_id_d   = write_id_q;
    write_val_d  = write_val_q;
    last_grant_d = last_grant_q;
    if (grant_a) begin
      write_id_d   = a_head.id;
      write_val_d  = a_head.val;
      last_grant_d = WB_PORT_A;
    end else if (grant_b) begin
      write_id_d   = b_head.id;
      write_val_d  = b_head.val;
      last_grant_d = WB_PORT_B;
    end
  end

  // Both ports accepting the same id on one edge is also a double-pending write.
  always_comb begin
    rs1_busy   = pending(rs1_id);
    rs2_busy   = pending(rs2_id);
    conflict_d = conflict_q
               || (a_push && pending(a_id))
               || (b_push && pending(b_id))
               || (a_push && b_push && (a_id == b_id));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_q         <= 1'b0;
      write_id_q   <= '0;
      write_val_q  <= '0;
      last_grant_q <= WB_PORT_B;
      conflict_q   <= 1'b0;
    end else begin
      we_q         <= we_d;
      write_id_q   <= write_id_d;
      write_val_q  <= write_val_d;
      last_grant_q <= last_grant_d;
      conflict_q   <= conflict_d;
    end
  end

  assign we        = we_q;
  assign write_id  = write_id_q;
  assign write_val = write_val_q;
  assign conflict  = conflict_q;

endmodule
